// File: rtl/rr_arbiter_sync.sv
// Clocked N-way round-robin arbiter. It shares one four-phase output channel among N
// four-phase requesters whose req/ack lines are asynchronous to clk.

module rr_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sh_q, sh_d;

   always_comb sh_d = {sh_q[STAGES-2:0], d};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sh_q <= '0;
      else     sh_q <= sh_d;
   end

   assign q = sh_q[STAGES-1];
endmodule

module rr_arbiter_sync #(
   parameter int N           = 4,
   parameter int SEL_W       = $clog2(N),
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_in,
   output logic [N-1:0]     ack_in,
   output logic             req_out,
   input  logic             ack_out,
   output logic [SEL_W-1:0] sel,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d, last_q, last_d, pick;
   logic [N-1:0]     ack_in_q, ack_in_d, rq, hi_mask, req_hi, grant_oh;
   logic             busy_q, busy_d, req_out_q, req_out_d, ak;

   for (genvar gi = 0; gi < N; gi++) begin : g_sync_req
      rr_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
         .clk (clk), .rst (rst), .d (req_in[gi]), .q (rq[gi])
      );
   end

   rr_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
      .clk (clk), .rst (rst), .d (ack_out), .q (ak)
   );

   function automatic logic [SEL_W-1:0] lowest(input logic [N-1:0] v);
      lowest = '0;
      for (int i = N - 1; i >= 0; i--)
         if (v[i]) lowest = SEL_W'(i);
   endfunction

   // Requests above the last grantee win first; otherwise wrap to the lowest set index.
   always_comb begin
      hi_mask  = ({N{1'b1}} << last_q) << 1;
      req_hi   = rq & hi_mask;
      pick     = (|req_hi) ? lowest(req_hi) : lowest(rq);
      grant_oh = N'(1) << sel_q;
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      last_d    = last_q;
      busy_d    = busy_q;
      req_out_d = req_out_q;
      ack_in_d  = ack_in_q;
      case (state_q)
         IDLE: if (|rq) begin
            sel_d     = pick;
            last_d    = pick;
            busy_d    = 1'b1;
            req_out_d = 1'b1;
            state_d   = REQ;
         end
         // A grantee withdrawing early is not acted on here; ACK then exits at once.
         REQ: if (ak) begin
            ack_in_d = grant_oh;
            state_d  = ACK;
         end
         ACK: if (!rq[sel_q]) begin
            req_out_d = 1'b0;
            state_d   = RTZ;
         end
         RTZ: if (!ak) begin
            ack_in_d = '0;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         last_q    <= SEL_W'(N - 1);
         busy_q    <= 1'b0;
         req_out_q <= 1'b0;
         ack_in_q  <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         req_out_q <= req_out_d;
         ack_in_q  <= ack_in_d;
      end
   end

   assign ack_in  = ack_in_q;
   assign req_out = req_out_q;
   assign sel     = sel_q;
   assign busy    = busy_q;
endmodule

// File: tb/tb_rr_arbiter_sync.sv
// Bench for rr_arbiter_sync: directed vector table, hand-written corner sequences,
// and randomized handshakes checked against a round-robin reference model.

module tb_rr_arbiter_sync;
   localparam int N     = 4;
   localparam int SEL_W = 2;
   localparam int SYNC  = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N-1:0]     req_in = '0;
   logic [N-1:0]     ack_in;
   logic             req_out;
   logic             ack_out = 1'b0;
   logic [SEL_W-1:0] sel;
   logic             busy;

   int total = 0;
   int bad   = 0;

   rr_arbiter_sync #(.N(N), .SEL_W(SEL_W), .SYNC_STAGES(SYNC)) dut (
      .clk (clk), .rst (rst), .req_in (req_in), .ack_in (ack_in),
      .req_out (req_out), .ack_out (ack_out), .sel (sel), .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // id: 0 = req_out, 1 = busy, 2 = any ack_in bit
   task automatic wait_for(input int id, input logic val, input string nm);
      logic cur;
      int   n;
      n = 0;
      cur = ~val;
      while (cur !== val && n <= 200) begin
         @(negedge clk);
         case (id)
            0:       cur = req_out;
            1:       cur = busy;
            default: cur = |ack_in;
         endcase
         n++;
      end
      if (cur !== val) begin
         total++;
         bad++;
         $display("FAIL timeout %s: got %0b want %0b", nm, cur, val);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_in = '0;
      ack_out = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ack_in", ack_in, 0);
      chk("rst_req_out", req_out, 0);
      chk("rst_sel", sel, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic handshake(input logic [N-1:0] pat, input int exp, input string tag);
      req_in = pat;
      wait_for(0, 1'b1, {tag, "_req"});
      chk({tag, "_sel"}, sel, exp);
      chk({tag, "_busy"}, busy, 1);
      ack_out = 1'b1;
      wait_for(2, 1'b1, {tag, "_ack"});
      chk({tag, "_ack_in"}, ack_in, 1 << exp);
      req_in = '0;
      wait_for(0, 1'b0, {tag, "_rtz"});
      ack_out = 1'b0;
      wait_for(1, 1'b0, {tag, "_idle"});
      chk({tag, "_ack_clr"}, ack_in, 0);
      repeat (3) @(negedge clk);
   endtask

   // Protocol monitor: phase ordering, one-hot acknowledge, no re-grant while busy.
   logic         mon_en = 1'b0;
   logic [N-1:0] prev_ack = '0;
   logic         prev_rout = 1'b0, prev_busy = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (ack_in !== prev_ack) chk("mon_onehot", {31'd0, $onehot0(ack_in)}, 1);
         if ((ack_in & ~prev_ack) != 0) chk("mon_ack_rise", {31'd0, ack_out}, 1);
         if ((prev_ack & ~ack_in) != 0) chk("mon_ack_fall", {31'd0, ack_out}, 0);
         if (!prev_rout && req_out) chk("mon_regrant", {31'd0, prev_busy}, 0);
         if (prev_rout && !req_out) chk("mon_rout_fall", {31'd0, req_in[sel]}, 0);
      end
      prev_ack  = ack_in;
      prev_rout = req_out;
      prev_busy = busy;
   end

   // Reference: first requester at or after (last+1) mod N.
   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   typedef struct {
      logic [N-1:0] req;
      int           sel;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int           n, idle, exp, last_m;
      logic [N-1:0] req_v, add;
      int           wait_cnt[N];

      vecs[0]  = '{4'b1111, 0};
      vecs[1]  = '{4'b1111, 1};
      vecs[2]  = '{4'b1111, 2};
      vecs[3]  = '{4'b1111, 3};
      vecs[4]  = '{4'b1001, 0};
      vecs[5]  = '{4'b1000, 3};
      vecs[6]  = '{4'b0110, 1};
      vecs[7]  = '{4'b0110, 2};
      vecs[8]  = '{4'b0001, 0};
      vecs[9]  = '{4'b1111, 1};
      vecs[10] = '{4'b0100, 2};
      vecs[11] = '{4'b1011, 3};

      do_reset();
      mon_en = 1'b1;

      // Single request with latency check
      @(negedge clk);
      req_in = 4'b0010;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_out && n < 50);
      chk("single_latency", n, SYNC + 1);
      chk("single_sel", sel, 1);
      chk("single_busy", busy, 1);
      chk("single_no_ack", ack_in, 0);
      ack_out = 1'b1;
      wait_for(2, 1'b1, "single_ack");
      chk("single_ack_in", ack_in, 4'b0010);
      req_in = '0;
      wait_for(0, 1'b0, "single_rtz");
      chk("single_rtz_ack", ack_in, 4'b0010);
      chk("single_rtz_busy", busy, 1);
      ack_out = 1'b0;
      wait_for(1, 1'b0, "single_idle");
      chk("single_ack_clr", ack_in, 0);

      mon_en = 1'b0;
      do_reset();
      mon_en = 1'b1;
      for (int i = 0; i < 12; i++) handshake(vecs[i].req, vecs[i].sel, $sformatf("vec%0d", i));

      // Arrival while busy: grant 2, raise 0 during ACK
      req_in = 4'b0100;
      wait_for(0, 1'b1, "arr_req");
      chk("arr_sel2", sel, 2);
      ack_out = 1'b1;
      wait_for(2, 1'b1, "arr_ack");
      chk("arr_ack2", ack_in, 4'b0100);
      req_in = 4'b0101;
      repeat (2) @(negedge clk);
      req_in = 4'b0001;
      wait_for(0, 1'b0, "arr_rtz");
      chk("arr_ack_hold", ack_in, 4'b0100);
      ack_out = 1'b0;
      wait_for(1, 1'b0, "arr_idle");
      chk("arr_ack_clr", ack_in, 0);
      idle = 1;
      n = 0;
      @(negedge clk);
      while (!req_out && n < 100) begin
         if (!busy) idle++;
         n++;
         @(negedge clk);
      end
      chk("arr_regrant", {31'd0, req_out}, 1);
      chk("arr_idle_gap", {31'd0, idle >= 1}, 1);
      chk("arr_sel0", sel, 0);
      ack_out = 1'b1;
      wait_for(2, 1'b1, "arr_ack0");
      chk("arr_ack0_in", ack_in, 4'b0001);
      req_in = '0;
      wait_for(0, 1'b0, "arr_rtz0");
      ack_out = 1'b0;
      wait_for(1, 1'b0, "arr_idle0");

      // Reset in the middle of ACK
      repeat (3) @(negedge clk);
      req_in = 4'b0100;
      wait_for(0, 1'b1, "mid_req");
      ack_out = 1'b1;
      wait_for(2, 1'b1, "mid_ack");
      chk("mid_ack_in", ack_in, 4'b0100);
      chk("mid_req_out", req_out, 1);
      mon_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ack", ack_in, 0);
      chk("mid_rst_rout", req_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_sel", sel, 0);
      ack_out = 1'b0;
      req_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      req_in = 4'b1111;
      mon_en = 1'b1;
      wait_for(0, 1'b1, "mid_regrant");
      chk("mid_first_sel", sel, 0);
      ack_out = 1'b1;
      wait_for(2, 1'b1, "mid_ack2");
      req_in = '0;
      wait_for(0, 1'b0, "mid_rtz2");
      ack_out = 1'b0;
      wait_for(1, 1'b0, "mid_idle2");

      // Randomized handshakes against the reference model
      mon_en = 1'b0;
      do_reset();
      mon_en = 1'b1;
      last_m = N - 1;
      req_v = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int h = 0; h < 1000; h++) begin
         if (req_v == 0) begin
            req_v = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            #($urandom_range(1, 25));
            req_in = req_v;
         end
         wait_for(0, 1'b1, "rnd_req");
         exp = rr_pick(req_v, last_m);
         chk("rnd_sel", sel, exp);
         chk("rnd_busy", busy, 1);
         chk("rnd_fair", {31'd0, wait_cnt[exp] <= N - 1}, 1);
         wait_cnt[exp] = 0;
         for (int i = 0; i < N; i++) if (req_v[i] && i != exp) wait_cnt[i]++;
         last_m = exp;
         #($urandom_range(1, 25));
         add = N'($urandom_range(0, (1 << N) - 1)) & ~req_v;
         for (int i = 0; i < N; i++) if (add[i]) wait_cnt[i] = 0;
         req_v = req_v | add;
         req_in = req_v;
         #($urandom_range(1, 25));
         ack_out = 1'b1;
         wait_for(2, 1'b1, "rnd_ack");
         chk("rnd_ack_in", ack_in, 1 << exp);
         #($urandom_range(1, 25));
         req_v[exp] = 1'b0;
         req_in = req_v;
         wait_for(0, 1'b0, "rnd_rtz");
         #($urandom_range(1, 25));
         ack_out = 1'b0;
         wait_for(1, 1'b0, "rnd_idle");
         chk("rnd_ack_clr", ack_in, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
